logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 158 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshake, chaining accumulator,
// registered result flags and a wrapping delivered-result counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_parity,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOTA = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_sel_q, s1_sel_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_zero_q, y_zero_d;
    logic             y_parity_q, y_parity_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] result;

    // Handshake: S1 may refill in the same cycle it drains into S2.
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s1_adv;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;
    end

    // Accumulator is read at the S1->S2 edge so consecutive beats chain.
    always_comb begin
        eff_a  = s1_sel_q ? acc_q : s1_a_q;
        result = '0;
        case (s1_op_q)
            OP_AND:  result = eff_a & s1_b_q;
            OP_OR:   result = eff_a | s1_b_q;
            OP_NOTA: result = ~eff_a;
            OP_NAND: result = ~(eff_a & s1_b_q);
            OP_NOR:  result = ~(eff_a | s1_b_q);
            OP_XOR:  result = eff_a ^ s1_b_q;
            OP_XNOR: result = ~(eff_a ^ s1_b_q);
            OP_PASS: result = s1_b_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_sel_d    = s1_sel_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_zero_d    = y_zero_q;
        y_parity_d  = y_parity_q;
        acc_d       = acc_q;
        res_count_d = res_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_a_d   = a;
            s1_b_d   = b;
            s1_op_d  = op;
            s1_sel_d = acc_sel;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            y_d         = result;
            y_zero_d    = (result == '0);
            y_parity_d  = ^result;
            acc_d       = result;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a same-edge result load.
        if (acc_clr) begin
            acc_d = '0;
        end

        if (out_fire) begin
            res_count_d = res_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_zero_q    <= 1'b0;
            y_parity_q  <= 1'b0;
            acc_q       <= '0;
            res_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_zero_q    <= y_zero_d;
            y_parity_q  <= y_parity_d;
            acc_q       <= acc_d;
            res_count_q <= res_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_zero    = y_zero_q;
    assign y_parity  = y_parity_q;
    assign acc       = acc_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and random checks of logic_unit_pipe against a transaction-level
// model: an in-flight queue of expected results in acceptance order.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] r;
        int               e;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_parity;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] res_count;

    beat_t            pipe[$];
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] macc;
    logic [CNT_W-1:0] cnt_m;
    int               edge_n;
    int               n_checks;
    int               n_fail;

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .acc_sel  (acc_sel),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .y_zero   (y_zero),
        .y_parity (y_parity),
        .acc      (acc),
        .res_count(res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~x;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return x ^ z;
            3'd6:    return ~(x ^ z);
            default: return z;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; checks outputs against the model before the edge.
    task automatic cycle(input bit iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [2:0] iop, input bit isel, input bit iclr, input bit ior,
                         output bit took);
        bit    exp_rdy;
        bit    exp_ov;
        beat_t bt;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        acc_sel   = isel;
        acc_clr   = iclr;
        out_ready = ior;
        #1;
        exp_ov  = (pipe.size() > 0) && (pipe[0].e < edge_n);
        exp_rdy = (pipe.size() < 2) || ior;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("res_count", 64'(res_count), 64'(cnt_m));
        if (exp_ov) begin
            chk("y", 64'(y), 64'(pipe[0].r));
            chk("y_zero", 64'(y_zero), 64'(pipe[0].r == '0));
            chk("y_parity", 64'(y_parity), 64'(^pipe[0].r));
            if (ior) begin
                got.push_back(y);
                void'(pipe.pop_front());
                cnt_m = cnt_m + CNT_W'(1);
            end
        end
        took = iv && exp_rdy;
        if (took) begin
            bt.r = ref_op(iop, isel ? macc : ia, ib);
            bt.e = edge_n + 1;
            pipe.push_back(bt);
            macc = bt.r;
        end
        @(posedge clk);
        edge_n++;
    endtask

    task automatic do_reset(input bit iv, input bit ior);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = iv;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        op        = 3'($urandom);
        acc_sel   = 1'b1;
        acc_clr   = 1'b0;
        out_ready = ior;
        @(posedge clk);
        edge_n++;
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        pipe.delete();
        macc  = '0;
        cnt_m = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_acc", 64'(acc), 64'(0));
        chk("rst_res_count", 64'(res_count), 64'(0));
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_y_zero", 64'(y_zero), 64'(0));
        chk("rst_y_parity", 64'(y_parity), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic drain(input int budget);
        bit t;
        for (int i = 0; i < budget && pipe.size() > 0; i++) begin
            cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, t);
        end
        chk("drain_empty", 64'(pipe.size()), 64'(0));
    endtask

    initial begin
        bit               t;
        int               idx;
        logic [WIDTH-1:0] sa[3];
        logic [WIDTH-1:0] sb[3];
        logic [2:0]       so[3];

        n_checks  = 0;
        n_fail    = 0;
        edge_n    = 0;
        cnt_m     = '0;
        macc      = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_sel   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset(1'b1, 1'b1);

        // Latency: accepted at one edge, result visible after the next.
        cycle(1'b1, 8'hF0, 8'h3C, 3'b101, 1'b0, 1'b0, 1'b1, t);
        #1 chk("lat_accept", 64'(t), 64'(1));
        chk("lat_not_yet", 64'(out_valid), 64'(0));
        cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, t);
        #1 chk("lat_out_valid", 64'(out_valid), 64'(1));
        chk("lat_y", 64'(y), 64'(8'hCC));
        chk("lat_y_zero", 64'(y_zero), 64'(0));
        chk("lat_y_parity", 64'(y_parity), 64'(0));
        drain(8);

        // Accumulator chain, back to back.
        got.delete();
        cycle(1'b1, 8'h00, 8'h0F, 3'b111, 1'b0, 1'b0, 1'b1, t);
        cycle(1'b1, 8'h00, 8'hA0, 3'b001, 1'b1, 1'b0, 1'b1, t);
        cycle(1'b1, 8'h00, 8'h00, 3'b010, 1'b1, 1'b0, 1'b1, t);
        drain(8);
        #1 chk("chain_count", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("chain_y0", 64'(got[0]), 64'(8'h0F));
            chk("chain_y1", 64'(got[1]), 64'(8'hAF));
            chk("chain_y2", 64'(got[2]), 64'(8'h50));
        end
        chk("chain_acc", 64'(acc), 64'(8'h50));

        // Stall with three beats offered.
        got.delete();
        sa[0] = 8'h12; sb[0] = 8'h34; so[0] = 3'b000;
        sa[1] = 8'h55; sb[1] = 8'h0F; so[1] = 3'b001;
        sa[2] = 8'hFF; sb[2] = 8'h00; so[2] = 3'b110;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(idx < 3, sa[idx % 3], sb[idx % 3], so[idx % 3], 1'b0, 1'b0, 1'b0, t);
            if (t) idx++;
        end
        #1 chk("stall_accepted", 64'(idx), 64'(2));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_y", 64'(y), 64'(8'h10));
        for (int i = 0; i < 10 && (idx < 3 || pipe.size() > 0); i++) begin
            cycle(idx < 3, sa[idx % 3], sb[idx % 3], so[idx % 3], 1'b0, 1'b0, 1'b1, t);
            if (t) idx++;
        end
        #1 chk("stall_count", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("stall_y0", 64'(got[0]), 64'(8'h10));
            chk("stall_y1", 64'(got[1]), 64'(8'h5F));
            chk("stall_y2", 64'(got[2]), 64'(8'h00));
        end

        // Clear coinciding with the S1->S2 transfer of 0x55.
        cycle(1'b1, 8'h00, 8'h55, 3'b111, 1'b0, 1'b0, 1'b1, t);
        cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1, t);
        #1 chk("clr_acc", 64'(acc), 64'(0));
        chk("clr_out_valid", 64'(out_valid), 64'(1));
        chk("clr_y", 64'(y), 64'(8'h55));
        macc = '0;
        drain(8);

        // Counter wrap with a 4-bit counter.
        do_reset(1'b0, 1'b1);
        got.delete();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1, t);
        end
        drain(8);
        #1 chk("wrap_delivered", 64'(got.size()), 64'(17));
        chk("wrap_res_count", 64'(res_count), 64'(1));

        // Random traffic, no clears, so acc always tracks the last result.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3) != 0, t);
        end
        drain(8);
        #1 chk("rand_acc", 64'(acc), 64'(macc));

        // Reset while both stages are full and stalled.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0, t);
        end
        #1 chk("full_in_ready", 64'(in_ready), 64'(0));
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
